// File: rtl/dma_pkg.sv
// Shared DMA definitions: RX controller states and the RAM map
// used by dma_rx, dma_tx and the CPU.
package dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        POP,
        WRITE,
        FLAG
    } dma_rx_state_t;

    localparam logic [7:0] DMA_RX_BUFFER_MSB = 8'h00;
    localparam logic [7:0] DMA_RX_BUFFER_MID = 8'h01;
    localparam logic [7:0] DMA_RX_BUFFER_LSB = 8'h02;
    localparam logic [7:0] NEW_INST          = 8'h03;

    // True when any byte of an n-byte frame at base lands on flag.
    function automatic bit frame_overlaps(
        input logic [7:0]  base,
        input int unsigned n,
        input logic [7:0]  flag
    );
        for (int unsigned k = 0; k < n; k++) begin
            if (8'(base + k[7:0]) == flag) begin
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/dma_rx.sv
// Receive DMA: pops bytes from the UART RX FIFO into RAM and
// writes a completion flag after every full frame.
module dma_rx
    import dma_pkg::*;
#(
    parameter int unsigned FRAME_BYTES   = 3,
    parameter logic [7:0]  BASE_ADDR     = DMA_RX_BUFFER_MSB,
    parameter logic [7:0]  NEW_INST_ADDR = NEW_INST,
    parameter logic [7:0]  NEW_INST_VAL  = 8'hFF
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Ena,
    input  logic       RX_Empty,
    input  logic [7:0] RX_Data,
    output logic       Data_Read,
    output logic       Bus_req,
    input  logic       Bus_grant,
    output logic [7:0] Address,
    output logic [7:0] Databus,
    output logic       Cs,
    output logic       Wen,
    output logic       Dma_Ready
);

    localparam int unsigned   IW   = $clog2(FRAME_BYTES);
    localparam logic [IW-1:0] LAST = IW'(FRAME_BYTES - 1);

    if (FRAME_BYTES < 2 || FRAME_BYTES > 8) begin : g_bad_len
        $error("dma_rx: FRAME_BYTES must be 2..8");
    end

    if (frame_overlaps(BASE_ADDR, FRAME_BYTES, NEW_INST_ADDR)) begin : g_overlap
        $error("dma_rx: frame overlaps NEW_INST_ADDR");
    end

    dma_rx_state_t state;
    dma_rx_state_t state_n;

    logic [IW-1:0] idx;
    logic [IW-1:0] idx_n;

    logic       bus_req_n;
    logic       ready_n;
    logic       data_read_n;
    logic       cs_n;
    logic [7:0] addr_n;
    logic       wr_sel;
    logic       wr_sel_n;
    logic       flag_sel;
    logic       flag_sel_n;

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        bus_req_n   = Bus_req;
        ready_n     = Dma_Ready;
        data_read_n = 1'b0;
        cs_n        = 1'b0;
        addr_n      = Address;
        wr_sel_n    = 1'b0;
        flag_sel_n  = 1'b0;

        unique case (state)
            IDLE: begin
                if (Ena && !RX_Empty) begin
                    state_n   = REQ;
                    bus_req_n = 1'b1;
                    ready_n   = 1'b0;
                end
            end
            REQ: begin
                if (Bus_grant) begin
                    if (!RX_Empty) begin
                        state_n     = POP;
                        data_read_n = 1'b1;
                    end else begin
                        state_n   = IDLE;
                        bus_req_n = 1'b0;
                        ready_n   = 1'b1;
                    end
                end
            end
            POP: begin
                state_n  = WRITE;
                cs_n     = 1'b1;
                addr_n   = BASE_ADDR + 8'(idx);
                wr_sel_n = 1'b1;
            end
            WRITE: begin
                if (idx == LAST) begin
                    state_n    = FLAG;
                    idx_n      = '0;
                    cs_n       = 1'b1;
                    addr_n     = NEW_INST_ADDR;
                    flag_sel_n = 1'b1;
                end else begin
                    idx_n = idx + IW'(1);
                    if (!RX_Empty) begin
                        state_n     = POP;
                        data_read_n = 1'b1;
                    end else begin
                        // Partial frame: give the bus back, resume at idx later.
                        state_n   = IDLE;
                        bus_req_n = 1'b0;
                        ready_n   = 1'b1;
                    end
                end
            end
            FLAG: begin
                state_n   = IDLE;
                bus_req_n = 1'b0;
                ready_n   = 1'b1;
            end
            default: begin
                state_n   = IDLE;
                bus_req_n = 1'b0;
                ready_n   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            Bus_req   <= 1'b0;
            Dma_Ready <= 1'b1;
            Data_Read <= 1'b0;
            Cs        <= 1'b0;
            Wen       <= 1'b0;
            Address   <= 8'h00;
            wr_sel    <= 1'b0;
            flag_sel  <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            Bus_req   <= bus_req_n;
            Dma_Ready <= ready_n;
            Data_Read <= data_read_n;
            Cs        <= cs_n;
            Wen       <= cs_n;
            Address   <= addr_n;
            wr_sel    <= wr_sel_n;
            flag_sel  <= flag_sel_n;
        end
    end

    // FIFO data is only valid in the WRITE cycle itself, so the byte is
    // steered from the registered FIFO output by a registered select.
    assign Databus = flag_sel ? NEW_INST_VAL :
                     wr_sel   ? RX_Data      : 8'h00;

endmodule
